parc_mem_responder: RTL and testbench
=====================================

Name: parc_mem_responder

Overview:
Memory-side responder for the PARC core's request/response memory interface (the imem_*/dmem_* bundles). It accepts one request per cycle with no backpressure and returns the response a fixed LATENCY cycles later, in order. Storage is a word-addressed array. The top level instantiates it twice: once for instruction memory, once for data memory. It is the target for core simulation and FPGA bring-up.

Parameters:
XLEN, 32, data and address width
DEPTH_WORDS, 4096, number of XLEN-bit words of storage (power of 2)
BASE_ADDR, 32'h8000_0000, byte address mapped to word 0 (matches core reset PC)
LATENCY, 2, cycles from an accepted request to its response; legal range 1..8

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous assert, active-low
mem_addr  in  XLEN  byte address, sampled when mem_req=1
mem_wdata  in  XLEN  store data, sampled when mem_req=1 and mem_we=1
mem_we  in  1  1 = write, 0 = read
mem_req  in  1  request valid; every cycle with mem_req=1 is one request
mem_data  out  XLEN  read data; valid when mem_resp=1
mem_resp  out  1  response valid, one cycle per request
mem_err  out  1  error flag qualified by mem_resp (misaligned or out of range)

Behaviour:
- Reset (rst=0, asynchronous): all delay-line valid bits clear. mem_resp=0, mem_data=0, mem_err=0.
  - In-flight responses are dropped; no response appears after reset releases.
  - Storage contents are not reset.
- Acceptance: a request is accepted on every rising edge where mem_req=1 and rst=1. There is no ready signal and the block never stalls.
- Address decode:
  - off = mem_addr - BASE_ADDR, computed modulo 2^XLEN.
  - idx = off[log2(DEPTH_WORDS)+1:2].
  - The request is in range if off < DEPTH_WORDS*4.
  - The request is misaligned if mem_addr[1:0] != 0.
  - err = !in_range | misaligned.
- Write (mem_we=1, err=0): the storage word at idx takes mem_wdata at the accepting edge. The response carries mem_data=0 and mem_err=0.
- Read (mem_we=0, err=0): data is captured from storage at the accepting edge.
  - Same-cycle ordering: a write accepted at edge N is visible to a read accepted at edge N+1 or later.
  - Requests are single-ported, so reads and writes never occur on the same edge.
- Error request: no storage update. The response carries mem_data=0 and mem_err=1.
- Delay line: a LATENCY-stage shift register holding {valid, data, err}.
  - Stage 0 loads at the accepting edge; it loads valid=0 when mem_req=0.
  - Outputs are driven from the last stage, registered, with no combinational path from inputs.
  - A request accepted at edge N gives mem_resp=1 during cycle N+LATENCY (after edge N+LATENCY-1 updates the last stage; with LATENCY=1 that is the cycle after the request).
- Back-to-back requests produce back-to-back responses in identical order. Throughput is 1 per cycle.
- When mem_resp=0: mem_data=0 and mem_err=0 (outputs are gated, never hold stale values).
- Address wrap: BASE_ADDR + DEPTH_WORDS*4 and any address below BASE_ADDR (wraps to a huge offset) are out of range and must not alias to word 0.
- X-safety: mem_addr, mem_wdata and mem_we are ignored when mem_req=0. No storage update occurs on those cycles.

Decomposition:
- Shared package parc_mem_pkg:
  - mem_req_t struct {addr, wdata, we}
  - mem_resp_t struct {data, err}
  - localparams for the default BASE_ADDR and LATENCY range
  - The core top is updated to use the same structs.
- One sub-module, parc_resp_delay: a parameterised LATENCY-stage valid/payload shift register with asynchronous active-low reset. It is reusable for other fixed-latency responders.
- Storage is inferred as a plain array inside parc_mem_responder.

Test Plan:
1. Reset latency: hold rst=0 for 3 cycles while mem_req=1 -> mem_resp stays 0 throughout and for LATENCY cycles after release; assert rst=1 with a read of 0x8000_0000 -> resp exactly LATENCY cycles later.
2. Write/read: write 0xDEAD_BEEF to 0x8000_0010 at edge N, read the same address at edge N+1 -> read response mem_data=0xDEAD_BEEF, mem_err=0; the write response has mem_data=0 and appears one cycle earlier.
3. Streaming: 8 consecutive reads of 0x8000_0000..0x8000_001C preloaded with 0..7 -> 8 consecutive mem_resp cycles returning 0..7 in order, no bubbles; repeat with LATENCY=1 and LATENCY=8.
4. Errors: read 0x8000_0002 -> mem_err=1, mem_data=0; write 0x7FFF_FFFC -> mem_err=1 and word 0 unchanged (a subsequent read of 0x8000_0000 returns its prior value); read 0x8000_4000 (DEPTH_WORDS=4096) -> mem_err=1.
5. Reset mid-flight: LATENCY=4, issue reads at edges 0-2, assert rst=0 asynchronously between edges 3 and 4 -> mem_resp drops immediately and no response appears for the dropped requests after release.
6. Gapped traffic: request pattern 1,0,1,1,0 -> mem_resp pattern identical, shifted by LATENCY; mem_data=0 on idle cycles.

Source files
------------

// File: rtl/parc_mem_pkg.sv
// Shared types and defaults for the PARC request/response memory interface.
package parc_mem_pkg;

  localparam int unsigned PARC_XLEN = 32;
  localparam logic [PARC_XLEN-1:0] PARC_BASE_ADDR = 32'h8000_0000;

  // Supported response latency window for fixed-latency responders.
  localparam int unsigned PARC_LATENCY_MIN = 1;
  localparam int unsigned PARC_LATENCY_MAX = 8;
  localparam int unsigned PARC_LATENCY_DEF = 2;

  // One request beat as presented by the core.
  typedef struct packed {
    logic [PARC_XLEN-1:0] addr;
    logic [PARC_XLEN-1:0] wdata;
    logic                 we;
  } mem_req_t;

  // One response beat returned to the core.
  typedef struct packed {
    logic [PARC_XLEN-1:0] data;
    logic                 err;
  } mem_resp_t;

  // Word accesses only: any set byte-offset bit is an error.
  function automatic logic is_misaligned(input logic [1:0] lsbs);
    return |lsbs;
  endfunction

endpackage

// File: rtl/parc_resp_delay.sv
// Fixed-latency valid/payload shift register with asynchronous active-low reset.
// Payload is zeroed on load when not valid, so the last stage never shows stale data.
module parc_resp_delay #(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned W       = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  input  logic [W-1:0] i_payload,
  output logic         o_valid,
  output logic [W-1:0] o_payload
);

  logic [LATENCY-1:0]        r_valid;
  logic [LATENCY-1:0][W-1:0] r_payload;

  // Shift valid and gated payload one stage per clock; reset drops everything in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid   <= '0;
      r_payload <= '0;
    end else begin
      r_valid[0]   <= i_valid;
      r_payload[0] <= i_valid ? i_payload : '0;
      for (int i = 1; i < LATENCY; i++) begin
        r_valid[i]   <= r_valid[i-1];
        r_payload[i] <= r_payload[i-1];
      end
    end
  end

  assign o_valid   = r_valid[LATENCY-1];
  assign o_payload = r_payload[LATENCY-1];

endmodule

// File: rtl/parc_mem_responder.sv
// Word-addressed memory responder: one request per cycle, in-order response
// exactly LATENCY cycles later. The registered storage read forms stage 0 of
// the response pipeline; the remaining LATENCY-1 stages live in parc_resp_delay.
module parc_mem_responder
  import parc_mem_pkg::*;
#(
  parameter int unsigned     XLEN        = PARC_XLEN,
  parameter int unsigned     DEPTH_WORDS = 4096,
  parameter logic [XLEN-1:0] BASE_ADDR   = XLEN'(PARC_BASE_ADDR),
  parameter int unsigned     LATENCY     = PARC_LATENCY_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_wdata,
  input  logic            mem_we,
  input  logic            mem_req,
  output logic [XLEN-1:0] mem_data,
  output logic            mem_resp,
  output logic            mem_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  // Word offset from the base; the subtraction wraps, so addresses below the
  // base become huge offsets and fall out of range instead of aliasing word 0.
  logic [XLEN-3:0] w_off_word;
  logic [AW-1:0]   w_idx;
  logic            w_in_range;
  logic            w_err;
  logic            w_accept;
  logic            w_wr_en;
  logic            w_rd_en;

  assign w_off_word = mem_addr[XLEN-1:2] - BASE_ADDR[XLEN-1:2];
  assign w_idx      = w_off_word[AW-1:0];
  assign w_in_range = (w_off_word[XLEN-3:AW] == '0);
  assign w_err      = !w_in_range || is_misaligned(mem_addr[1:0]);
  assign w_accept   = mem_req && rst;
  assign w_wr_en    = w_accept && mem_we && !w_err;
  assign w_rd_en    = w_accept && !mem_we && !w_err;

  logic [XLEN-1:0] r_mem [DEPTH_WORDS];
  logic [XLEN-1:0] r_rd_data;

  // Storage: synchronous write, registered read; left unreset so it maps to block RAM.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_idx] <= mem_wdata;
    end
    if (w_rd_en) begin
      r_rd_data <= r_mem[w_idx];
    end
  end

  logic r_s0_valid;
  logic r_s0_rd;
  logic r_s0_err;

  // Stage 0 control: marks which accepted requests are reads and which are errors.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s0_valid <= 1'b0;
      r_s0_rd    <= 1'b0;
      r_s0_err   <= 1'b0;
    end else begin
      r_s0_valid <= mem_req;
      r_s0_rd    <= w_rd_en;
      r_s0_err   <= mem_req && w_err;
    end
  end

  // Only successful reads carry storage data; writes, errors and idle carry zero.
  logic [XLEN-1:0] w_s0_data;
  assign w_s0_data = r_s0_rd ? r_rd_data : '0;

  if (LATENCY <= 1) begin : g_direct
    assign mem_resp = r_s0_valid;
    assign mem_data = w_s0_data;
    assign mem_err  = r_s0_err;
  end else begin : g_delay
    logic [XLEN:0] w_dly_payload;

    parc_resp_delay #(
      .LATENCY (LATENCY - 1),
      .W       (XLEN + 1)
    ) u_delay (
      .clk       (clk),
      .rst       (rst),
      .i_valid   (r_s0_valid),
      .i_payload ({w_s0_data, r_s0_err}),
      .o_valid   (mem_resp),
      .o_payload (w_dly_payload)
    );

    assign mem_data = w_dly_payload[XLEN:1];
    assign mem_err  = w_dly_payload[0];
  end

endmodule

// File: tb/tb_parc_mem_responder.sv
// Bench for parc_mem_responder: four instances (LATENCY 1,2,4,8) share one
// stimulus stream and are checked every cycle against a transaction-level model.
module tb_parc_mem_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int NI   = 4;
  localparam int MAXE = 2048;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_we = 1'b0;
  logic        mem_req = 1'b0;
  logic        resp_o [NI];
  logic [31:0] data_o [NI];
  logic        err_o  [NI];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    parc_mem_responder #(
      .XLEN        (32),
      .DEPTH_WORDS (4096),
      .BASE_ADDR   (BASE),
      .LATENCY     (1 << gi)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_req   (mem_req),
      .mem_data  (data_o[gi]),
      .mem_resp  (resp_o[gi]),
      .mem_err   (err_o[gi])
    );
  end

  // Transaction model: per accepted edge, the response it must produce.
  logic [31:0] model_mem [int];
  bit          acc_v [MAXE];
  logic [31:0] acc_d [MAXE];
  bit          acc_e [MAXE];
  // Directed-table expectations, checked on the LATENCY=2 instance.
  bit          dir_has [MAXE];
  bit          dir_v [MAXE];
  logic [31:0] dir_d [MAXE];
  bit          dir_e [MAXE];

  int edge_cnt = 0;
  int rst_mark = -1;
  int checks   = 0;
  int errors   = 0;

  typedef struct {
    bit          req;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          exp_v;
    logic [31:0] exp_d;
    bit          exp_e;
  } vec_t;

  vec_t tbl [11];

  function automatic bit addr_err(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (off >= 32'd16384) || (a[1:0] != 2'b00);
  endfunction

  task automatic model_edge(input int e);
    bit er;
    int w;
    if (e >= MAXE) begin
      errors++;
      $display("FAIL edge_budget: edge %0d exceeds %0d", e, MAXE);
      $fatal(1);
    end
    acc_v[e] = 0;
    acc_d[e] = '0;
    acc_e[e] = 0;
    if (!rst) begin
      rst_mark = e;
    end else if (mem_req) begin
      er = addr_err(mem_addr);
      w  = int'((mem_addr - BASE) >> 2);
      acc_v[e] = 1;
      acc_e[e] = er;
      if (!er) begin
        if (mem_we) model_mem[w] = mem_wdata;
        else if (model_mem.exists(w)) acc_d[e] = model_mem[w];
      end
    end
  endtask

  task automatic check(input int k);
    int n;
    bit ev, ee;
    logic [31:0] ed;
    for (int i = 0; i < NI; i++) begin
      n  = k - (1 << i) + 1;
      ev = 0; ed = '0; ee = 0;
      if (n >= 0 && n < MAXE && acc_v[n] && n > rst_mark) begin
        ev = 1; ed = acc_d[n]; ee = acc_e[n];
      end
      checks++;
      if (resp_o[i] !== ev || data_o[i] !== ed || err_o[i] !== ee) begin
        errors++;
        $display("FAIL resp_L%0d edge%0d: got resp=%0b data=%h err=%0b, expected resp=%0b data=%h err=%0b",
                 1 << i, k, resp_o[i], data_o[i], err_o[i], ev, ed, ee);
      end
      if (i == 1 && n >= 0 && n < MAXE && dir_has[n]) begin
        checks++;
        if (resp_o[i] !== dir_v[n] || data_o[i] !== dir_d[n] || err_o[i] !== dir_e[n]) begin
          errors++;
          $display("FAIL table_row edge%0d: got resp=%0b data=%h err=%0b, expected resp=%0b data=%h err=%0b",
                   n, resp_o[i], data_o[i], err_o[i], dir_v[n], dir_d[n], dir_e[n]);
        end
      end
    end
  endtask

  // One clock: drive inputs, model the accepting edge, sample on the falling edge.
  task automatic step(input bit req, input bit we, input logic [31:0] addr, input logic [31:0] wd);
    mem_req = req;
    if (req) begin
      mem_we = we; mem_addr = addr; mem_wdata = wd;
    end else begin
      mem_we = 1'($urandom); mem_addr = $urandom; mem_wdata = $urandom;
    end
    @(posedge clk);
    model_edge(edge_cnt);
    @(negedge clk);
    if (!rst) rst_mark = edge_cnt;
    check(edge_cnt);
    $display("edge %0d rst=%0b req=%0b we=%0b addr=%h | L1 r=%0b d=%h e=%0b | L8 r=%0b d=%h e=%0b",
             edge_cnt, rst, req, mem_we, mem_addr, resp_o[0], data_o[0], err_o[0],
             resp_o[3], data_o[3], err_o[3]);
    edge_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0);
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r <= 6) return BASE + 32'(4 * $urandom_range(0, 31));
    if (r == 7) return BASE + 32'h3FFC;
    if (r == 8) return BASE + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(1, 3));
    case ($urandom_range(0, 3))
      0: return BASE + 32'h4000;
      1: return BASE - 32'd4;
      2: return 32'h0;
      default: return BASE + 32'h4000 + 32'(4 * $urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1, 1, 32'h8000_0010, 32'hDEAD_BEEF, 1, 32'h0,         0};
    tbl[1]  = '{1, 0, 32'h8000_0010, 32'h0,         1, 32'hDEAD_BEEF, 0};
    tbl[2]  = '{1, 0, 32'h8000_0002, 32'h0,         1, 32'h0,         1};
    tbl[3]  = '{1, 1, 32'h7FFF_FFFC, 32'h0000_1234, 1, 32'h0,         1};
    tbl[4]  = '{1, 0, 32'h8000_0000, 32'h0,         1, 32'h0,         0};
    tbl[5]  = '{1, 0, 32'h8000_4000, 32'h0,         1, 32'h0,         1};
    tbl[6]  = '{1, 0, 32'h8000_0004, 32'h0,         1, 32'h1,         0};
    tbl[7]  = '{0, 0, 32'h0,         32'h0,         0, 32'h0,         0};
    tbl[8]  = '{1, 0, 32'h8000_0008, 32'h0,         1, 32'h2,         0};
    tbl[9]  = '{1, 0, 32'h8000_000C, 32'h0,         1, 32'h3,         0};
    tbl[10] = '{0, 0, 32'h0,         32'h0,         0, 32'h0,         0};

    // Power-up reset.
    rst = 1'b0;
    idle(2);
    rst = 1'b1;

    // Preload: words 0..7 hold their index; 8..31 and the last word random.
    for (int w = 0; w < 8; w++) step(1, 1, BASE + 32'(4 * w), 32'(w));
    for (int w = 8; w < 32; w++) step(1, 1, BASE + 32'(4 * w), $urandom);
    step(1, 1, BASE + 32'h3FFC, $urandom);
    idle(8);

    // Reset held 3 cycles with requests (writes to word 0) that must be ignored.
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step(1, 1, BASE, 32'h0000_0BAD);
    rst = 1'b1;
    step(1, 0, BASE, '0);
    idle(8);

    // Streaming reads of words 0..7, no gaps.
    for (int i = 0; i < 8; i++) step(1, 0, BASE + 32'(4 * i), '0);
    idle(8);

    // Directed table: write/read ordering, errors, gapped traffic.
    for (int i = 0; i < 11; i++) begin
      dir_has[edge_cnt] = 1;
      dir_v[edge_cnt]   = tbl[i].exp_v;
      dir_d[edge_cnt]   = tbl[i].exp_d;
      dir_e[edge_cnt]   = tbl[i].exp_e;
      step(tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].wdata);
    end
    idle(8);

    // Reset mid-flight: reads at three edges, asynchronous reset after the fourth.
    for (int i = 1; i <= 3; i++) step(1, 0, BASE + 32'(4 * i), '0);
    mem_req = 1'b0;
    @(posedge clk);
    model_edge(edge_cnt);
    #1;
    check(edge_cnt);
    #1;
    rst = 1'b0;
    rst_mark = edge_cnt;
    #1;
    check(edge_cnt);
    @(negedge clk);
    rst = 1'b1;
    check(edge_cnt);
    $display("edge %0d async reset pulse after edge, released before next edge", edge_cnt);
    edge_cnt++;
    idle(10);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), rand_addr(), $urandom);
    end
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
